svc_sim_exit_ctrl: RTL and testbench

// - Program-lifecycle controller for RISC-V SoC sims: watches CPU MMIO

---
 rtl/svc_sim_exit_ctrl.sv | 172 +++++++++++++++++
 tb/tb_svc_sim_exit_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/svc_sim_exit_ctrl.sv
// rtl/svc_sim_exit_ctrl.sv - simulation lifecycle controller: per-hart exit capture, watchdog, UART drain
module svc_sim_exit_ctrl #(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] EXIT_ADDR       = 'h8000_0000,
    parameter int                NUM_CH          = 1,
    parameter int                ALL_MODE        = 0,
    parameter int                WATCHDOG_CYCLES = 1_000_000,
    parameter int                WDOG_IDLE       = 0,
    parameter int                DRAIN_CYCLES    = 4096,
    parameter int                CNT_W           = 32,
    localparam int               CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic              retire,
    input  logic              uart_busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       exit_code,
    output logic [CH_W-1:0]   exit_ch,
    output logic [NUM_CH-1:0] ch_exited,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_TOUT} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] exited_q, exited_d;
    logic [31:0]       code_q [NUM_CH];
    logic [31:0]       code_d [NUM_CH];
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tout_q, tout_d;
    logic [31:0]       exit_code_q, exit_code_d;
    logic [CH_W-1:0]   exit_ch_q, exit_ch_d;

    logic [NUM_CH-1:0] hit;
    logic              nz_found;
    logic [CH_W-1:0]   nz_idx, any_idx;
    logic [31:0]       nz_code, any_code;
    logic              exit_now, exit_with_hit, wdog_exp;

    always_comb begin
        state_d     = state_q;
        exited_d    = exited_q;
        code_d      = code_q;
        cycles_d    = cycles_q;
        wdog_d      = wdog_q;
        drain_d     = drain_q;
        done_d      = done_q;
        pass_d      = pass_q;
        tout_d      = tout_q;
        exit_code_d = exit_code_q;
        exit_ch_d   = exit_ch_q;

        hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_valid && (wr_strb == 4'hF) && (wr_addr == EXIT_ADDR + ADDR_W'(4 * c)))
                hit[c] = 1'b1;
        end

        // Descending scan so the lowest index wins each category.
        nz_found = 1'b0;
        nz_idx   = '0;
        nz_code  = '0;
        any_idx  = '0;
        any_code = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (exited_q[c]) begin
                any_idx  = CH_W'(c);
                any_code = code_q[c];
                if (code_q[c] != '0) begin
                    nz_found = 1'b1;
                    nz_idx   = CH_W'(c);
                    nz_code  = code_q[c];
                end
            end
        end

        exit_now      = (ALL_MODE != 0) ? (&exited_q) : (|exited_q);
        exit_with_hit = (ALL_MODE != 0) ? (&(exited_q | hit)) : (|(exited_q | hit));
        wdog_exp      = (WATCHDOG_CYCLES != 0) && (wdog_q >= CNT_W'(WATCHDOG_CYCLES));

        case (state_q)
            S_RUN: begin
                exited_d = exited_q | hit;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (hit[c] && !exited_q[c])
                        code_d[c] = wr_data;
                end
                if (exit_now) begin
                    state_d = S_DRAIN;
                    drain_d = CNT_W'(1);
                end else if (wdog_exp) begin
                    // An exit landing on the expiry cycle still counts as a clean exit.
                    if (exit_with_hit) begin
                        state_d = S_DRAIN;
                        drain_d = CNT_W'(1);
                    end else begin
                        state_d = S_TOUT;
                        done_d  = 1'b1;
                        tout_d  = 1'b1;
                    end
                end else begin
                    if (cycles_q != '1)
                        cycles_d = cycles_q + CNT_W'(1);
                    if ((WDOG_IDLE != 0) && retire)
                        wdog_d = '0;
                    else if (wdog_q != '1)
                        wdog_d = wdog_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!uart_busy || (drain_q >= CNT_W'(DRAIN_CYCLES))) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    pass_d      = !nz_found;
                    exit_code_d = nz_found ? nz_code : any_code;
                    exit_ch_d   = nz_found ? nz_idx : any_idx;
                end else if (drain_q != '1) begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            exited_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) code_q[c] <= '0;
            cycles_q    <= '0;
            wdog_q      <= '0;
            drain_q     <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tout_q      <= 1'b0;
            exit_code_q <= '0;
            exit_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            exited_q    <= exited_d;
            code_q      <= code_d;
            cycles_q    <= cycles_d;
            wdog_q      <= wdog_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tout_q      <= tout_d;
            exit_code_q <= exit_code_d;
            exit_ch_q   <= exit_ch_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = tout_q;
    assign exit_code = exit_code_q;
    assign exit_ch   = exit_ch_q;
    assign ch_exited = exited_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_svc_sim_exit_ctrl.sv
// tb/tb_svc_sim_exit_ctrl.sv - directed self-checking bench for svc_sim_exit_ctrl
module tb_svc_sim_exit_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, wr_valid, retire, uart_busy;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic        a_done, a_pass, a_tout, a_ch;
    logic [31:0] a_code, a_cyc;
    logic [0:0]  a_exited;
    logic        b_done, b_pass, b_tout, b_ch;
    logic [31:0] b_code, b_cyc;
    logic [0:0]  b_exited;
    logic        c_done, c_pass, c_tout, c_ch;
    logic [31:0] c_code, c_cyc;
    logic [0:0]  c_exited;
    logic        d_done, d_pass, d_tout;
    logic [1:0]  d_ch;
    logic [31:0] d_code, d_cyc;
    logic [3:0]  d_exited;
    logic        e_done, e_pass, e_tout;
    logic [1:0]  e_ch;
    logic [31:0] e_code, e_cyc;
    logic [3:0]  e_exited;

    svc_sim_exit_ctrl #(.NUM_CH(1), .WATCHDOG_CYCLES(1000), .DRAIN_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .retire(retire), .uart_busy(uart_busy), .done(a_done), .pass(a_pass),
        .timeout(a_tout), .exit_code(a_code), .exit_ch(a_ch), .ch_exited(a_exited), .cycles(a_cyc));

    svc_sim_exit_ctrl #(.NUM_CH(1), .WATCHDOG_CYCLES(50), .DRAIN_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .retire(retire), .uart_busy(uart_busy), .done(b_done), .pass(b_pass),
        .timeout(b_tout), .exit_code(b_code), .exit_ch(b_ch), .ch_exited(b_exited), .cycles(b_cyc));

    svc_sim_exit_ctrl #(.NUM_CH(1), .WATCHDOG_CYCLES(50), .WDOG_IDLE(1)) u_c (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .retire(retire), .uart_busy(uart_busy), .done(c_done), .pass(c_pass),
        .timeout(c_tout), .exit_code(c_code), .exit_ch(c_ch), .ch_exited(c_exited), .cycles(c_cyc));

    svc_sim_exit_ctrl #(.NUM_CH(4), .ALL_MODE(1), .WATCHDOG_CYCLES(0), .DRAIN_CYCLES(16)) u_d (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .retire(retire), .uart_busy(uart_busy), .done(d_done), .pass(d_pass),
        .timeout(d_tout), .exit_code(d_code), .exit_ch(d_ch), .ch_exited(d_exited), .cycles(d_cyc));

    svc_sim_exit_ctrl #(.NUM_CH(4), .ALL_MODE(0), .WATCHDOG_CYCLES(0)) u_e (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .retire(retire), .uart_busy(uart_busy), .done(e_done), .pass(e_pass),
        .timeout(e_tout), .exit_code(e_code), .exit_ch(e_ch), .ch_exited(e_exited), .cycles(e_cyc));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 of a fresh run.
    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; retire = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        step(1);
        wr_valid = 1'b0; wr_strb = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; retire = 1'b0; uart_busy = 1'b0;
        step(2);
        checks++; if ({a_done, a_pass, a_tout, a_exited} !== 4'b0) begin errors++; $display("FAIL reset_a_flags got %b want 0000", {a_done, a_pass, a_tout, a_exited}); end
        checks++; if (a_cyc !== 32'd0) begin errors++; $display("FAIL reset_a_cycles got %0d want 0", a_cyc); end
        checks++; if ({d_exited, d_code, d_ch} !== 38'd0) begin errors++; $display("FAIL reset_d_status got %h want 0", {d_exited, d_code, d_ch}); end
        checks++; if (b_tout !== 1'b0) begin errors++; $display("FAIL reset_b_timeout got %b want 0", b_tout); end
        rst = 1'b0;
    endtask

    task automatic test_basic_pass();
        do_reset(); uart_busy = 1'b0;
        step(100);
        bus_write(BASE, 32'd0, 4'hF);
        checks++; if (a_exited !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL basic_c101 got exited=%b done=%b want 1,0", a_exited, a_done); end
        step(1);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_c102_done got %b want 0", a_done); end
        step(1);
        checks++; if (a_done !== 1'b1 || a_pass !== 1'b1 || a_tout !== 1'b0) begin errors++; $display("FAIL basic_done_pass got done=%b pass=%b tout=%b want 1,1,0", a_done, a_pass, a_tout); end
        checks++; if (a_code !== 32'd0) begin errors++; $display("FAIL basic_code got %0d want 0", a_code); end
        checks++; if (a_cyc !== 32'd101) begin errors++; $display("FAIL basic_cycles got %0d want 101", a_cyc); end
    endtask

    task automatic test_drain_limit();
        do_reset(); uart_busy = 1'b1;
        step(5);
        bus_write(BASE, 32'd3, 4'hF);
        bus_write(BASE, 32'd9, 4'hF);
        step(15);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL drain_early got done=%b want 0", a_done); end
        step(1);
        checks++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin errors++; $display("FAIL drain_done got done=%b pass=%b want 1,0", a_done, a_pass); end
        checks++; if (a_code !== 32'd3) begin errors++; $display("FAIL drain_first_code got %0d want 3", a_code); end
        checks++; if (a_cyc !== 32'd6) begin errors++; $display("FAIL drain_cycles got %0d want 6", a_cyc); end
        uart_busy = 1'b0;
        step(5);
        checks++; if (a_done !== 1'b1 || a_code !== 32'd3 || a_cyc !== 32'd6) begin errors++; $display("FAIL drain_hold got done=%b code=%0d cyc=%0d want 1,3,6", a_done, a_code, a_cyc); end
    endtask

    task automatic test_ignored_writes();
        do_reset(); uart_busy = 1'b0;
        step(2);
        bus_write(BASE, 32'd5, 4'h1);
        bus_write(BASE + 32'd4, 32'd5, 4'hF);
        bus_write(BASE, 32'd5, 4'h7);
        step(2);
        checks++; if (a_exited !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL ignored_writes got exited=%b done=%b want 0,0", a_exited, a_done); end
    endtask

    task automatic test_watchdog();
        do_reset(); uart_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            retire = ((i % 10) == 9);
            if (i == 50) begin
                checks++; if (b_tout !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL wdog_c50 got tout=%b done=%b want 0,0", b_tout, b_done); end
            end
            if (i == 51) begin
                checks++; if (b_tout !== 1'b1 || b_done !== 1'b1 || b_pass !== 1'b0 || b_code !== 32'd0) begin errors++; $display("FAIL wdog_c51 got tout=%b done=%b pass=%b code=%0d want 1,1,0,0", b_tout, b_done, b_pass, b_code); end
            end
            step(1);
        end
        retire = 1'b0;
        checks++; if (c_tout !== 1'b0 || c_done !== 1'b0) begin errors++; $display("FAIL wdog_idle got tout=%b done=%b want 0,0", c_tout, c_done); end
        checks++; if (b_tout !== 1'b1 || b_cyc !== 32'd50) begin errors++; $display("FAIL wdog_hold got tout=%b cyc=%0d want 1,50", b_tout, b_cyc); end
    endtask

    task automatic test_exit_at_expiry();
        do_reset(); uart_busy = 1'b0;
        step(50);
        bus_write(BASE, 32'd0, 4'hF);
        checks++; if (b_tout !== 1'b0 || b_done !== 1'b0 || b_exited !== 1'b1) begin errors++; $display("FAIL expiry_c51 got tout=%b done=%b exited=%b want 0,0,1", b_tout, b_done, b_exited); end
        step(1);
        checks++; if (b_done !== 1'b1 || b_tout !== 1'b0 || b_pass !== 1'b1) begin errors++; $display("FAIL expiry_done got done=%b tout=%b pass=%b want 1,0,1", b_done, b_tout, b_pass); end
    endtask

    task automatic test_all_mode();
        do_reset(); uart_busy = 1'b0;
        step(2);
        bus_write(BASE, 32'd0, 4'hF);
        step(1);
        bus_write(BASE + 32'd4, 32'd0, 4'hF);
        checks++; if (e_done !== 1'b1 || e_pass !== 1'b1 || e_ch !== 2'd0 || e_exited !== 4'b0001) begin errors++; $display("FAIL any_mode got done=%b pass=%b ch=%0d exited=%b want 1,1,0,0001", e_done, e_pass, e_ch, e_exited); end
        step(1);
        bus_write(BASE + 32'd8, 32'd0, 4'hF);
        checks++; if (d_exited !== 4'b0111 || d_done !== 1'b0) begin errors++; $display("FAIL all_partial got exited=%b done=%b want 0111,0", d_exited, d_done); end
        step(1);
        bus_write(BASE + 32'd12, 32'd7, 4'hF);
        step(1);
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL all_drain got done=%b want 0", d_done); end
        step(1);
        checks++; if (d_done !== 1'b1 || d_pass !== 1'b0) begin errors++; $display("FAIL all_done got done=%b pass=%b want 1,0", d_done, d_pass); end
        checks++; if (d_ch !== 2'd3 || d_code !== 32'd7) begin errors++; $display("FAIL all_select got ch=%0d code=%0d want 3,7", d_ch, d_code); end
        checks++; if (d_cyc !== 32'd9) begin errors++; $display("FAIL all_cycles got %0d want 9", d_cyc); end
    endtask

    task automatic test_rst_in_drain();
        do_reset(); uart_busy = 1'b1;
        step(3);
        bus_write(BASE, 32'd4, 4'hF);
        step(1);
        checks++; if (a_done !== 1'b0 || a_exited !== 1'b1) begin errors++; $display("FAIL rst_pre got done=%b exited=%b want 0,1", a_done, a_exited); end
        rst = 1'b1;
        step(1);
        checks++; if ({a_done, a_pass, a_tout, a_exited} !== 4'b0 || a_cyc !== 32'd0 || a_code !== 32'd0) begin errors++; $display("FAIL rst_clear got flags=%b cyc=%0d code=%0d want 0", {a_done, a_pass, a_tout, a_exited}, a_cyc, a_code); end
        rst = 1'b0; uart_busy = 1'b0;
        step(3);
        checks++; if (a_cyc !== 32'd3) begin errors++; $display("FAIL rst_restart got cyc=%0d want 3", a_cyc); end
        bus_write(BASE, 32'd0, 4'hF);
        step(2);
        checks++; if (a_done !== 1'b1 || a_pass !== 1'b1) begin errors++; $display("FAIL rst_rerun got done=%b pass=%b want 1,1", a_done, a_pass); end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_drain_limit();
        test_ignored_writes();
        test_watchdog();
        test_exit_at_expiry();
        test_all_mode();
        test_rst_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
